// File: rtl/mod_inv_pkg.sv
// Shared types and constants for the binary extended-GCD modular inverse engine.
package mod_inv_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_STEP  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_MOD  = 2'd1;
  localparam logic [1:0] ERR_OPND = 2'd2;
  localparam logic [1:0] ERR_WDOG = 2'd3;

  localparam int DEF_W = 256;

endpackage

// File: rtl/mod_half_sub.sv
// Combinational modular halve (x/2 mod p) and modular subtract (x-y mod p); x, y in [0,p-1], p odd.
module mod_half_sub #(
  parameter int W = 256
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] p,
  output logic [W-1:0] half,
  output logic [W-1:0] diff
);

  // x+p needs the extra carry bit before the shift, otherwise large moduli wrap
  logic [W:0] sum;

  assign sum  = {1'b0, x} + {1'b0, p};
  assign half = x[0] ? sum[W:1] : (x >> 1);
  assign diff = (x >= y) ? (x - y) : (x - y + p);

endmodule

// File: rtl/mod_inv_bxgcd.sv
// Iterative modular inverse a^-1 mod p (odd p) by binary extended GCD, one reduction step per clock.
// state | meaning
// IDLE  | waiting for a start rising edge
// CHECK | validate modulus and operand
// STEP  | one halve/subtract reduction per cycle
// FIN   | publish result, pulse done
module mod_inv_bxgcd
  import mod_inv_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int MAX_ITER = 4*W+4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] p,
  output logic         busy,
  output logic [W-1:0] inv,
  output logic         done,
  output logic         error,
  output logic [1:0]   err_code
);

  localparam int IW = $clog2(MAX_ITER+1);

  state_t         state;
  logic           start_q;
  logic [W-1:0]   pr, u, v, x1, x2;
  logic [IW-1:0]  it;
  logic [1:0]     ecode;
  logic [W-1:0]   x1_half, x1_diff, x2_half, x2_diff;

  mod_half_sub #(.W(W)) u_hs_x1 (.x(x1), .y(x2), .p(pr), .half(x1_half), .diff(x1_diff));
  mod_half_sub #(.W(W)) u_hs_x2 (.x(x2), .y(x1), .p(pr), .half(x2_half), .diff(x2_diff));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      start_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= ERR_OK;
      inv      <= '0;
      pr       <= '0;
      u        <= '0;
      v        <= '0;
      x1       <= '0;
      x2       <= '0;
      it       <= '0;
      ecode    <= ERR_OK;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !start_q && !busy) begin
            pr       <= p;
            u        <= a;
            v        <= p;
            x1       <= W'(1);
            x2       <= '0;
            it       <= '0;
            busy     <= 1'b1;
            error    <= 1'b0;
            err_code <= ERR_OK;
            ecode    <= ERR_OK;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!pr[0] || pr < W'(3)) begin
            ecode <= ERR_MOD;
            state <= S_FIN;
          end else if (u == '0 || u >= pr) begin
            ecode <= ERR_OPND;
            state <= S_FIN;
          end else begin
            state <= S_STEP;
          end
        end
        S_STEP: begin
          if (u == W'(1) || v == W'(1)) begin
            state <= S_FIN;
          end else if (u == '0 || v == '0) begin
            ecode <= ERR_OPND;
            state <= S_FIN;
          end else if (it == IW'(MAX_ITER)) begin
            ecode <= ERR_WDOG;
            state <= S_FIN;
          end else begin
            it <= it + IW'(1);
            if (!u[0]) begin
              u  <= u >> 1;
              x1 <= x1_half;
            end else if (!v[0]) begin
              v  <= v >> 1;
              x2 <= x2_half;
            end else if (u >= v) begin
              u  <= u - v;
              x1 <= x1_diff;
            end else begin
              v  <= v - u;
              x2 <= x2_diff;
            end
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
          // u and v are untouched by the terminating step, so u==1 still selects x1
          if (ecode == ERR_OK) begin
            inv <= (u == W'(1)) ? x1 : x2;
          end else begin
            inv      <= '0;
            error    <= 1'b1;
            err_code <= ecode;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inv_bxgcd.sv
// Scoreboard bench for mod_inv_bxgcd: driver queues expectations, a negedge monitor checks each done.
module tb_mod_inv_bxgcd;

  localparam int W = 256;
  localparam logic [255:0] SECP = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] SECP_INV2 = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18;

  typedef struct {
    logic         err;
    logic [1:0]   code;
    logic [255:0] inv;
    int           exact_lat;
    int           max_lat;
    longint       acc;
    string        name;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   p = '0;
  logic           busy;
  logic [W-1:0]   inv;
  logic           done;
  logic           error;
  logic [1:0]     err_code;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;
  exp_t   sb[$];
  exp_t   mon_e;
  longint mon_lat;

  mod_inv_bxgcd #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .p(p),
    .busy(busy), .inv(inv), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [255:0] act, logic [255:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endfunction

  function automatic exp_t mk(logic err, logic [1:0] code, logic [255:0] iv,
                              int exact_lat, int max_lat, string nm);
    exp_t e;
    e.err = err; e.code = code; e.inv = iv;
    e.exact_lat = exact_lat; e.max_lat = max_lat; e.acc = 0; e.name = nm;
    return e;
  endfunction

  // Reference via classic extended Euclid (division based)
  function automatic exp_t model(logic [255:0] av, logic [255:0] pv, int max_lat, string nm);
    logic signed [519:0] r0, r1, t0, t1, qq, tmp;
    if (!pv[0] || pv < 3) return mk(1'b1, 2'd1, '0, -1, 0, nm);
    if (av == 0 || av >= pv) return mk(1'b1, 2'd2, '0, -1, 0, nm);
    r0 = {264'd0, pv}; r1 = {264'd0, av}; t0 = 0; t1 = 1;
    while (r1 != 0) begin
      qq = r0 / r1;
      tmp = r0 - qq * r1; r0 = r1; r1 = tmp;
      tmp = t0 - qq * t1; t0 = t1; t1 = tmp;
    end
    if (r0 != 1) return mk(1'b1, 2'd2, '0, -1, max_lat, nm);
    if (t0 < 0) t0 = t0 + {264'd0, pv};
    return mk(1'b0, 2'd0, t0[255:0], -1, max_lat, nm);
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: done=1 with no run pending at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        mon_lat = cyc - mon_e.acc;
        chk({mon_e.name, " error"}, {255'd0, error}, {255'd0, mon_e.err});
        chk({mon_e.name, " err_code"}, {254'd0, err_code}, {254'd0, mon_e.code});
        chk({mon_e.name, " inv"}, inv, mon_e.inv);
        if (mon_e.exact_lat >= 0) chk({mon_e.name, " latency"}, 256'(mon_lat), 256'(mon_e.exact_lat));
        if (mon_e.max_lat > 0) begin
          n_cmp++;
          if (mon_lat > mon_e.max_lat) begin
            n_bad++;
            $display("FAIL %s latency_bound: got %0d required <= %0d", mon_e.name, mon_lat, mon_e.max_lat);
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: still busy after %0d cycles, required done", nm, budget);
      sb.delete();
    end
  endtask

  task automatic issue(input logic [255:0] av, input logic [255:0] pv, input exp_t e);
    @(posedge clk); #1;
    a = av; p = pv; start = 1'b1;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = '1; p = '1;
  endtask

  task automatic run(input logic [255:0] av, input logic [255:0] pv, input exp_t e);
    issue(av, pv, e);
    wait_idle(3000, e.name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [31:0] rp, ra;
    #13;
    chk("reset busy", {255'd0, busy}, 256'd0);
    chk("reset done", {255'd0, done}, 256'd0);
    chk("reset error", {255'd0, error}, 256'd0);
    chk("reset err_code", {254'd0, err_code}, 256'd0);
    chk("reset inv", inv, 256'd0);
    @(negedge clk); rst_n = 1'b1;

    run(256'd2, 256'd13, mk(1'b0, 2'd0, 256'd7, -1, 0, "p13_a2"));
    run(256'd5, 256'd13, mk(1'b0, 2'd0, 256'd8, -1, 0, "p13_a5"));
    run(256'd1, SECP, mk(1'b0, 2'd0, 256'd1, 3, 0, "secp_a1"));
    run(256'd2, SECP, mk(1'b0, 2'd0, SECP_INV2, -1, 0, "secp_a2"));

    run(256'd0, 256'd13, mk(1'b1, 2'd2, '0, -1, 0, "p13_a0"));
    run(256'd6, 256'd15, mk(1'b1, 2'd2, '0, -1, 0, "p15_a6_gcd3"));
    run(256'd3, 256'd14, mk(1'b1, 2'd1, '0, -1, 0, "p14_even"));
    run(256'd13, 256'd13, mk(1'b1, 2'd2, '0, -1, 0, "p13_a13"));

    // start level held high: exactly one run
    @(posedge clk); #1;
    a = 256'd2; p = 256'd13; start = 1'b1;
    begin
      exp_t e = mk(1'b0, 2'd0, 256'd7, -1, 0, "held_start");
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    repeat (50) @(posedge clk);
    #1 start = 1'b0;
    wait_idle(100, "held_start");

    // edges while busy are ignored
    issue(256'd3, SECP, model(256'd3, SECP, 0, "secp_a3_pulsed"));
    chk("busy during long run", {255'd0, busy}, 256'd1);
    repeat (3) begin
      @(posedge clk); #1 start = 1'b1; a = 256'd5; p = 256'd13;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_idle(3000, "secp_a3_pulsed");
    run(256'd5, 256'd13, mk(1'b0, 2'd0, 256'd8, -1, 0, "after_pulses"));

    // asynchronous reset in the middle of STEP
    issue(256'd3, SECP, model(256'd3, SECP, 0, "secp_a3_aborted"));
    repeat (20) @(posedge clk);
    #2;
    chk("busy before abort", {255'd0, busy}, 256'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("abort busy", {255'd0, busy}, 256'd0);
    chk("abort done", {255'd0, done}, 256'd0);
    chk("abort error", {255'd0, error}, 256'd0);
    chk("abort err_code", {254'd0, err_code}, 256'd0);
    chk("abort inv", inv, 256'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(256'd3, SECP, model(256'd3, SECP, 0, "secp_a3_after_reset"));

    // 32-bit operand sweep checked against the Euclid reference
    for (int i = 0; i < 200; i++) begin
      rp = $urandom | 32'h1;
      if (rp < 3) rp = 32'd5;
      ra = ($urandom % (rp - 1)) + 1;
      run({224'd0, ra}, {224'd0, rp}, model({224'd0, ra}, {224'd0, rp}, 3 + 4*32, "rand32"));
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
